// File: rtl/banked_mem_resp.sv
// Four-bank 16-bit memory with per-bank busy timers, a two-cycle read pipeline,
// and a stall on requests to busy banks. Optional macro BANK_CONFLICT_ERR_EN also raises err on a bank conflict.
module banked_mem_resp (
    input  logic        clk,
    input  logic        rst,
    input  logic        createdump,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);

    localparam logic [2:0] BUSY_LOAD = 3'd4;

    logic [1:0]  bank;
    logic [12:0] row;
    logic        req;
    logic        illegal;
    logic        legal;
    logic        conflict;
    logic        accept;
    logic [2:0]  cnt [4];
    logic [15:0] mem [4][8192];
    logic [15:0] rd_word;
    logic        rd_v1;
    logic        unused_dump;

    // The dump request has no effect on responses.
    assign unused_dump = createdump;

    assign bank     = addr[2:1];
    assign row      = addr[15:3];
    assign req      = rd | wr;
    assign illegal  = (rd & wr) | addr[0];
    assign legal    = req & ~illegal & ~rst;
    assign conflict = legal & busy[bank];
    assign accept   = legal & ~conflict;
    assign stall    = conflict;

`ifdef BANK_CONFLICT_ERR_EN
    assign err = (req & illegal & ~rst) | conflict;
`else
    assign err = req & illegal & ~rst;
`endif

    always_comb begin
        busy = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            busy[b] = (cnt[b] != 3'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                cnt[b] <= 3'd0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (accept && bank == 2'(b)) begin
                    cnt[b] <= BUSY_LOAD;
                end else if (cnt[b] != 3'd0) begin
                    cnt[b] <= cnt[b] - 3'd1;
                end
            end
        end
    end

    // Array is never reset; the read port samples every cycle and the
    // pipeline valid bit decides whether the word is ever presented.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            mem[bank][row] <= data_in;
        end
        rd_word <= mem[bank][row];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_v1    <= 1'b0;
            data_out <= 16'h0000;
        end else begin
            rd_v1    <= accept & rd;
            data_out <= rd_v1 ? rd_word : 16'h0000;
        end
    end

endmodule

// File: tb/tb_banked_mem_resp.sv
// Directed bench for banked_mem_resp: stimulus pushes expected read results
// with their due cycle; a negedge monitor pops and compares data_out.
module tb_banked_mem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        createdump;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic [15:0] d;
    } exp_t;
    exp_t sb[$];

`ifdef BANK_CONFLICT_ERR_EN
    localparam logic CONF_ERR = 1'b1;
`else
    localparam logic CONF_ERR = 1'b0;
`endif

    banked_mem_resp dut (
        .clk        (clk),
        .rst        (rst),
        .createdump (createdump),
        .addr       (addr),
        .data_in    (data_in),
        .wr         (wr),
        .rd         (rd),
        .data_out   (data_out),
        .stall      (stall),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Monitor: data_out must match the queued word in its due cycle and be 0 otherwise.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            chk("data_out", data_out, sb[0].d);
            void'(sb.pop_front());
        end else if (data_out !== 16'h0000) begin
            chk("data_out_idle", data_out, 16'h0000);
        end
    end

    // One request cycle: drive, check stall/err/busy mid-cycle, optionally expect a read result at +2.
    task automatic cyc_do(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic es, input logic ee, input logic [3:0] eb,
                          input logic push, input logic [15:0] ed);
        rd = r; wr = w; addr = a; data_in = d;
        @(negedge clk);
        chk("stall", 16'(stall), 16'(es));
        chk("err",   16'(err),   16'(ee));
        chk("busy",  16'(busy),  16'(eb));
        if (push) sb.push_back('{cyc + 2, ed});
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            rd = 1'b0; wr = 1'b0; addr = 16'h0000; data_in = 16'h0000;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; createdump = 1'b0; rd = 1'b0; wr = 1'b0;
        addr = 16'h0000; data_in = 16'h0000;
        @(posedge clk); #1;
        // Requests during reset are ignored and flags stay low.
        cyc_do(1, 0, 16'h0000, 16'h0, 0, 0, 4'b0000, 0, 16'h0);
        chk("rst_data_out", data_out, 16'h0000);
        rst = 1'b0;
        cyc_do(0, 0, 16'h0000, 16'h0, 0, 0, 4'b0000, 0, 16'h0);

        // Write then read of the same word, five cycles apart.
        createdump = 1'b1;
        cyc_do(0, 1, 16'h0010, 16'hBEEF, 0, 0, 4'b0000, 0, 16'h0);
        createdump = 1'b0;
        repeat (4) cyc_do(0, 0, 16'h0000, 16'h0, 0, 0, 4'b0001, 0, 16'h0);
        cyc_do(1, 0, 16'h0010, 16'h0, 0, 0, 4'b0000, 1, 16'hBEEF);
        repeat (4) cyc_do(0, 0, 16'h0000, 16'h0, 0, 0, 4'b0001, 0, 16'h0);
        cyc_do(0, 0, 16'h0000, 16'h0, 0, 0, 4'b0000, 0, 16'h0);

        // Fill one word per bank back to back.
        cyc_do(0, 1, 16'h0000, 16'h1111, 0, 0, 4'b0000, 0, 16'h0);
        cyc_do(0, 1, 16'h0002, 16'h2222, 0, 0, 4'b0001, 0, 16'h0);
        cyc_do(0, 1, 16'h0004, 16'h3333, 0, 0, 4'b0011, 0, 16'h0);
        cyc_do(0, 1, 16'h0006, 16'h4444, 0, 0, 4'b0111, 0, 16'h0);
        cyc_do(0, 0, 16'h0000, 16'h0, 0, 0, 4'b1111, 0, 16'h0);
        cyc_do(0, 0, 16'h0000, 16'h0, 0, 0, 4'b1110, 0, 16'h0);
        cyc_do(0, 0, 16'h0000, 16'h0, 0, 0, 4'b1100, 0, 16'h0);
        cyc_do(0, 0, 16'h0000, 16'h0, 0, 0, 4'b1000, 0, 16'h0);
        cyc_do(0, 1, 16'h000A, 16'hAAAA, 0, 0, 4'b0000, 0, 16'h0);
        idle(5);

        // Same-bank conflict: second read stalls four cycles then goes.
        cyc_do(1, 0, 16'h0002, 16'h0, 0, 0, 4'b0000, 1, 16'h2222);
        repeat (4) cyc_do(1, 0, 16'h000A, 16'h0, 1, CONF_ERR, 4'b0010, 0, 16'h0);
        cyc_do(1, 0, 16'h000A, 16'h0, 0, 0, 4'b0000, 1, 16'hAAAA);
        idle(5);

        // Reads to all four banks back to back return in order.
        cyc_do(1, 0, 16'h0000, 16'h0, 0, 0, 4'b0000, 1, 16'h1111);
        cyc_do(1, 0, 16'h0002, 16'h0, 0, 0, 4'b0001, 1, 16'h2222);
        cyc_do(1, 0, 16'h0004, 16'h0, 0, 0, 4'b0011, 1, 16'h3333);
        cyc_do(1, 0, 16'h0006, 16'h0, 0, 0, 4'b0111, 1, 16'h4444);
        cyc_do(0, 0, 16'h0000, 16'h0, 0, 0, 4'b1111, 0, 16'h0);
        idle(5);

        // Write one bank, read another the next cycle.
        cyc_do(0, 1, 16'h0014, 16'h5A5A, 0, 0, 4'b0000, 0, 16'h0);
        cyc_do(1, 0, 16'h0006, 16'h0, 0, 0, 4'b0100, 1, 16'h4444);
        idle(5);

        // Illegal requests: rd&wr, then odd address.
        cyc_do(1, 1, 16'h0000, 16'hDEAD, 0, 1, 4'b0000, 0, 16'h0);
        cyc_do(1, 0, 16'h0001, 16'h0, 0, 1, 4'b0000, 0, 16'h0);
        cyc_do(0, 0, 16'h0000, 16'h0, 0, 0, 4'b0000, 0, 16'h0);

        // Reset with a read in flight: result dropped, memory kept.
        cyc_do(1, 0, 16'h0004, 16'h0, 0, 0, 4'b0000, 0, 16'h0);
        rst = 1'b1;
        cyc_do(1, 0, 16'h0000, 16'h0, 0, 0, 4'b0000, 0, 16'h0);
        rst = 1'b0;
        cyc_do(0, 0, 16'h0000, 16'h0, 0, 0, 4'b0000, 0, 16'h0);
        cyc_do(1, 0, 16'h0004, 16'h0, 0, 0, 4'b0000, 1, 16'h3333);
        cyc_do(1, 0, 16'h0000, 16'h0, 0, 0, 4'b0100, 1, 16'h1111);
        idle(5);
        cyc_do(1, 0, 16'h0014, 16'h0, 0, 0, 4'b0000, 1, 16'h5A5A);
        idle(6);

        chk("sb_drained", 16'(sb.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
